// File: rtl/control_in_sampler_pkg.sv
// control_in_sampler_pkg
// Shared types and helpers for the control_in capture block.
//   smp_mode_e   : trigger mode selector encoding
//   ctl_rec_t    : record layout at the default widths (IW=16, FW=3, SEQ_W=8)
//   rec_width()  : record width for arbitrary IW/FW/SEQ_W
//   sat_inc()    : saturating increment for counters up to 32 bits wide
package control_in_sampler_pkg;

    typedef enum logic [1:0] {
        SMP_ALL        = 2'd0,  // capture every enabled cycle
        SMP_CHANGE     = 2'd1,  // capture when the bus payload changes
        SMP_INSTR_RISE = 2'd2,  // capture on complete_instr rising edge
        SMP_COMPLETE   = 2'd3   // capture while complete_instr|complete_data
    } smp_mode_e;

    localparam int IW_DEF    = 16;
    localparam int FW_DEF    = 3;
    localparam int SEQ_W_DEF = 8;

    // Head record, MSB first; the top builds the same concatenation for any widths.
    typedef struct packed {
        logic [SEQ_W_DEF-1:0] seq;
        logic [IW_DEF-1:0]    ir;
        logic [FW_DEF-1:0]    psr;
        logic [IW_DEF-1:0]    ir_exec;
        logic [IW_DEF-1:0]    imem_dout;
        logic [FW_DEF-1:0]    nzp;
        logic                 complete_data;
        logic                 complete_instr;
    } ctl_rec_t;

    localparam int REC_W_DEF = $bits(ctl_rec_t);

    function automatic int rec_width(input int iw, input int fw, input int seq_w);
        return seq_w + 3 * iw + 2 * fw + 2;
    endfunction

    // Increments value, holding at the all-ones pattern of the given width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/control_in_fifo.sv
// control_in_fifo
// Synchronous first-word-fall-through FIFO.
//   clk      : clock, rising edge
//   srst     : synchronous active-high reset, empties the FIFO
//   push     : write request; ignored when full unless a pop happens the same cycle
//   wr_data  : data to write
//   pop      : read request; ignored when empty
//   rd_valid : FIFO non-empty
//   rd_data  : head entry (zero while empty)
//   fill     : number of valid entries, 0..DEPTH
module control_in_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    fill
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             not_empty;
    logic             do_pop;
    logic             do_push;

    assign not_empty = (count_reg != '0);
    assign do_pop    = pop && not_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push   = push && ((count_reg != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; stale entries are never visible because
    // the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_valid = not_empty;
    assign rd_data  = not_empty ? mem[rd_ptr_reg] : '0;
    assign fill     = count_reg;

endmodule

// File: rtl/control_in_sampler.sv
// control_in_sampler
// Captures the LC3 control_in bus under a selectable trigger, tags each
// record with a wrapping sequence number and buffers it in a FWFT FIFO.
//   clock, reset         : clock and synchronous active-high reset
//   complete_data .. NZP : sampled bus signals
//   enable               : 0 suppresses all triggers
//   mode                 : trigger mode (see smp_mode_e)
//   out_ready            : consumer takes the head record
//   clear_stats          : clears drop_cnt and overflow (wins over a drop)
//   out_valid/out_data   : head record {seq, IR, psr, IR_Exec, IMem_dout, NZP, cd, ci}
//   fill                 : FIFO occupancy
//   drop_cnt             : saturating count of records lost to a full FIFO
//   overflow             : sticky drop indicator
module control_in_sampler
    import control_in_sampler_pkg::*;
#(
    parameter  int IW     = 16,
    parameter  int FW     = 3,
    parameter  int DEPTH  = 8,
    parameter  int SEQ_W  = 8,
    parameter  int DROP_W = 16,
    localparam int REC_W  = rec_width(IW, FW, SEQ_W),
    localparam int PAY_W  = REC_W - SEQ_W,
    localparam int FILL_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              complete_data,
    input  logic              complete_instr,
    input  logic [IW-1:0]     IR,
    input  logic [FW-1:0]     psr,
    input  logic [IW-1:0]     IR_Exec,
    input  logic [IW-1:0]     IMem_dout,
    input  logic [FW-1:0]     NZP,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              out_ready,
    input  logic              clear_stats,
    output logic              out_valid,
    output logic [REC_W-1:0]  out_data,
    output logic [FILL_W-1:0] fill,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overflow
);

    smp_mode_e         mode_e;
    logic [PAY_W-1:0]  payload;
    logic [SEQ_W-1:0]  seq_reg;
    logic [PAY_W-1:0]  last_reg;
    logic              first_flag_reg;
    logic              prev_ci_reg;
    logic [DROP_W-1:0] drop_cnt_reg;
    logic [DROP_W-1:0] drop_cnt_next;
    logic              overflow_reg;
    logic              trigger;
    logic              pop;
    logic              fifo_full;
    logic              drop;

    assign mode_e  = smp_mode_e'(mode);
    assign payload = {IR, psr, IR_Exec, IMem_dout, NZP, complete_data, complete_instr};

    always_comb begin
        trigger = 1'b0;
        if (enable) begin
            case (mode_e)
                SMP_ALL:        trigger = 1'b1;
                SMP_CHANGE:     trigger = first_flag_reg || (payload != last_reg);
                SMP_INSTR_RISE: trigger = complete_instr && !prev_ci_reg;
                SMP_COMPLETE:   trigger = complete_instr || complete_data;
                default:        trigger = 1'b0;
            endcase
        end
    end

    assign pop           = out_valid && out_ready;
    assign fifo_full     = (fill == FILL_W'(DEPTH));
    assign drop          = trigger && fifo_full && !pop;
    assign drop_cnt_next = DROP_W'(sat_inc(32'(drop_cnt_reg), DROP_W));

    always_ff @(posedge clock) begin
        if (reset) begin
            seq_reg        <= '0;
            last_reg       <= '0;
            first_flag_reg <= 1'b1;
            prev_ci_reg    <= 1'b0;
            drop_cnt_reg   <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            // Edge history tracks the bus even while capture is disabled.
            prev_ci_reg <= complete_instr;
            // seq advances on dropped records too, leaving a visible gap.
            if (trigger) begin
                seq_reg        <= seq_reg + SEQ_W'(1);
                last_reg       <= payload;
                first_flag_reg <= 1'b0;
            end
            if (clear_stats) begin
                drop_cnt_reg <= '0;
                overflow_reg <= 1'b0;
            end else if (drop) begin
                drop_cnt_reg <= drop_cnt_next;
                overflow_reg <= 1'b1;
            end
        end
    end

    control_in_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk      (clock),
        .srst     (reset),
        .push     (trigger),
        .wr_data  ({seq_reg, payload}),
        .pop      (pop),
        .rd_valid (out_valid),
        .rd_data  (out_data),
        .fill     (fill)
    );

    assign drop_cnt = drop_cnt_reg;
    assign overflow = overflow_reg;

endmodule
